// File: rtl/fwd_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_pkg
// Shared types and helpers for the forwarding / load-use hazard unit.
//   fwd_tag_t       : one in-flight destination tag {valid, reg_write,
//                     mem_read, rd}. rd is stored zero-extended to
//                     FWD_RD_MAX_W bits, so REG_ADDR_W may be at most 8.
//   FWD_SEL_REGFILE : forward select value meaning "read the register file".
//   fwd_sel_width() : width of one forward select for N forwarding stages.
// ---------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

    localparam int FWD_RD_MAX_W    = 8;
    localparam int FWD_SEL_REGFILE = 0;

    typedef struct packed {
        logic                    valid;
        logic                    reg_write;
        logic                    mem_read;
        logic [FWD_RD_MAX_W-1:0] rd;
    } fwd_tag_t;

    // Enough bits to encode 0 (regfile) plus stages 1..num_stages.
    function automatic int fwd_sel_width(input int num_stages);
        return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_if
// Bundle between the decode/execute stages and the hazard unit.
//   master : pipeline side; drives pipe_advance, flush, the ID-stage
//            instruction fields and the EX-stage source indices, and
//            receives fwd_sel, load_use_stall and stall_cnt.
//   slave  : hazard unit side (the reverse directions).
// Source vectors pack operand 0 in the least significant slice.
// ---------------------------------------------------------------------------
interface fwd_hazard_unit_if
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int NUM_SRC        = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int CNT_W          = 16,
    parameter int SEL_W          = fwd_sel_width(NUM_FWD_STAGES)
);

    logic                          pipe_advance;
    logic                          flush;
    logic                          id_valid;
    logic [REG_ADDR_W-1:0]         id_rd;
    logic                          id_reg_write;
    logic                          id_mem_read;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
    logic [NUM_SRC-1:0]            id_rs_used;
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          load_use_stall;
    logic [CNT_W-1:0]              stall_cnt;

    modport master (
        output pipe_advance, flush, id_valid, id_rd, id_reg_write,
               id_mem_read, id_rs, id_rs_used, ex_rs,
        input  fwd_sel, load_use_stall, stall_cnt
    );

    modport slave (
        input  pipe_advance, flush, id_valid, id_rd, id_reg_write,
               id_mem_read, id_rs, id_rs_used, ex_rs,
        output fwd_sel, load_use_stall, stall_cnt
    );

endinterface

// File: rtl/fwd_hazard_unit_fwd_match_prio.sv
// ---------------------------------------------------------------------------
// fwd_match_prio
// Priority encoder for one EX-stage source operand. Compares rs_i against
// the post-EX tags (stage 1 = EX/MEM, stage 2 = MEM/WB, ...) and returns
// the nearest stage holding a live write to that register, or 0 when the
// operand must come from the register file.
//   tags_i : tags for stages 1..NUM_FWD_STAGES
//   rs_i   : source register index, zero-extended to FWD_RD_MAX_W
//   sel_o  : 0 = regfile, k = forward from stage k
// ---------------------------------------------------------------------------
module fwd_match_prio
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int SEL_W          = fwd_sel_width(NUM_FWD_STAGES)
) (
    input  fwd_tag_t [NUM_FWD_STAGES:1] tags_i,
    input  logic [FWD_RD_MAX_W-1:0]     rs_i,
    output logic [SEL_W-1:0]            sel_o
);

    logic [NUM_FWD_STAGES:1] hit;
    logic                    unused_mem_read;

    // A stage can forward only if it really writes a non-zero register;
    // x0 is hardwired to zero and must never be bypassed.
    always_comb begin
        hit = '0;
        for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
            hit[k] = tags_i[k].valid && tags_i[k].reg_write &&
                     (tags_i[k].rd != '0) && (tags_i[k].rd == rs_i);
        end
    end

    // Scan from the oldest stage down so the youngest matching writer
    // (smallest k) overrides any older one.
    always_comb begin
        sel_o = SEL_W'(FWD_SEL_REGFILE);
        for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
            if (hit[k]) begin
                sel_o = SEL_W'(k);
            end
        end
    end

    // The load flag plays no part in forwarding once past EX.
    always_comb begin
        unused_mem_read = 1'b0;
        for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
            unused_mem_read = unused_mem_read ^ tags_i[k].mem_read;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Tracks in-flight destination registers in a tag pipeline that mirrors
// EX (tag[0]) and the post-EX stages (tag[1..NUM_FWD_STAGES]). From it
// produces per-operand forward selects for the EX instruction and the
// load-use stall for the ID instruction, plus a saturating count of
// load-use stall cycles.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all tags and the counter
//   bus   : fwd_hazard_unit_if slave port (pipeline control, ID/EX fields,
//           fwd_sel, load_use_stall, stall_cnt)
// REG_ADDR_W must not exceed FWD_RD_MAX_W (8).
// ---------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int NUM_SRC        = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int CNT_W          = 16,
    parameter int SEL_W          = fwd_sel_width(NUM_FWD_STAGES)
) (
    input  logic             clk,
    input  logic             reset,
    fwd_hazard_unit_if.slave bus
);

    fwd_tag_t [NUM_FWD_STAGES:0] tag_q;
    fwd_tag_t [NUM_FWD_STAGES:0] tag_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic [NUM_SRC-1:0]          src_hit;
    logic                        load_use;
    logic [NUM_SRC*SEL_W-1:0]    sel_vec;

    // Load-use: the EX instruction is a load whose result is not ready
    // until after MEM, and a used ID operand names its (non-x0) target.
    // A flushed ID instruction is being killed anyway, so it never stalls.
    always_comb begin
        src_hit = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_hit[s] = bus.id_rs_used[s] &&
                (FWD_RD_MAX_W'(bus.id_rs[s*REG_ADDR_W +: REG_ADDR_W]) == tag_q[0].rd);
        end
        load_use = bus.id_valid && !bus.flush && tag_q[0].valid &&
                   tag_q[0].mem_read && (tag_q[0].rd != '0) && (|src_hit);
    end

    // Next-state of the tag pipeline and the stall counter. A global hold
    // freezes everything, flush included. On advance the tags shift by one
    // stage and EX receives either a bubble (flush or stall) or the ID
    // instruction's destination information.
    always_comb begin
        tag_d = tag_q;
        cnt_d = cnt_q;
        if (bus.pipe_advance) begin
            for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
                tag_d[k] = tag_q[k-1];
            end
            if (bus.flush || load_use) begin
                tag_d[0] = '0;
            end else begin
                tag_d[0].valid     = bus.id_valid;
                tag_d[0].reg_write = bus.id_reg_write;
                tag_d[0].mem_read  = bus.id_mem_read;
                tag_d[0].rd        = FWD_RD_MAX_W'(bus.id_rd);
            end
            if (load_use && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset empties the pipeline so forwards and stalls
    // drop out immediately rather than at the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
            cnt_q <= '0;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end

    // One priority encoder per EX source operand.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match_prio #(
            .NUM_FWD_STAGES(NUM_FWD_STAGES),
            .SEL_W         (SEL_W)
        ) u_prio (
            .tags_i(tag_q[NUM_FWD_STAGES:1]),
            .rs_i  (FWD_RD_MAX_W'(bus.ex_rs[s*REG_ADDR_W +: REG_ADDR_W])),
            .sel_o (sel_vec[s*SEL_W +: SEL_W])
        );
    end

    assign bus.fwd_sel        = sel_vec;
    assign bus.load_use_stall = load_use;
    assign bus.stall_cnt      = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Directed bench for fwd_hazard_unit (2 forwarding stages, 2 sources,
// 5-bit register indices, 2-bit stall counter). Each step drives the ID/EX
// fields, queues the hand-derived expected outputs, and compares them a
// moment later, well clear of the clock edges.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;
    import fwd_hazard_unit_pkg::*;

    localparam int NFS = 2;
    localparam int NS  = 2;
    localparam int RAW = 5;
    localparam int CW  = 2;
    localparam int SW  = 2;

    logic clk;
    logic reset;

    fwd_hazard_unit_if #(
        .NUM_FWD_STAGES(NFS), .NUM_SRC(NS), .REG_ADDR_W(RAW),
        .CNT_W(CW), .SEL_W(SW)
    ) bus ();

    fwd_hazard_unit #(
        .NUM_FWD_STAGES(NFS), .NUM_SRC(NS), .REG_ADDR_W(RAW),
        .CNT_W(CW), .SEL_W(SW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [NS*SW-1:0] sel;
        logic             stall;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ID-stage instruction fields.
    task automatic setId(input logic v, input logic [RAW-1:0] rd,
                         input logic rw, input logic mr,
                         input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs0,
                         input logic [1:0] used);
        bus.id_valid     = v;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_rs        = {rs1, rs0};
        bus.id_rs_used   = used;
    endtask

    task automatic pushExpect(input logic [NS*SW-1:0] sel, input logic stall,
                              input logic [CW-1:0] cnt);
        exp_t e;
        e.sel   = sel;
        e.stall = stall;
        e.cnt   = cnt;
        expQ.push_back(e);
    endtask

    // Pipeline control and EX sources; queues the expected outputs.
    task automatic applyStimulus(input logic adv, input logic fl,
                                 input logic [RAW-1:0] ex1, input logic [RAW-1:0] ex0,
                                 input logic [SW-1:0] eSel1, input logic [SW-1:0] eSel0,
                                 input logic eStall, input logic [CW-1:0] eCnt);
        bus.pipe_advance = adv;
        bus.flush        = fl;
        bus.ex_rs        = {ex1, ex0};
        pushExpect({eSel1, eSel0}, eStall, eCnt);
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        #1;
        if (expQ.size() == 0) begin
            checkCount++;
            failCount++;
            $error("[TB] FAIL %s: observed DUT output with no queued expectation", name);
        end else begin
            e = expQ.pop_front();
            checkCount++;
            assert (bus.fwd_sel === e.sel) passCount++;
            else begin
                failCount++;
                $error("[TB] FAIL %s fwd_sel: observed %h expected %h", name, bus.fwd_sel, e.sel);
            end
            checkCount++;
            assert (bus.load_use_stall === e.stall) passCount++;
            else begin
                failCount++;
                $error("[TB] FAIL %s load_use_stall: observed %b expected %b", name, bus.load_use_stall, e.stall);
            end
            checkCount++;
            assert (bus.stall_cnt === e.cnt) passCount++;
            else begin
                failCount++;
                $error("[TB] FAIL %s stall_cnt: observed %0d expected %0d", name, bus.stall_cnt, e.cnt);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name);
        checkOutput(name);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 2'b00);
        bus.pipe_advance = 1'b0;
        bus.flush        = 1'b0;
        bus.ex_rs        = '0;
        #1 reset = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_state");
        tick();
        reset = 1'b0;

        // Back-to-back ALU dependency on x5.
        setId(1, 5, 1, 0, 0, 0, 2'b00);
        applyStimulus(1, 0, 5, 5, 0, 0, 0, 0);  step("alu_issue");
        setId(1, 6, 1, 0, 5, 5, 2'b11);
        applyStimulus(1, 0, 1, 2, 0, 0, 0, 0);  step("alu_consumer_id");
        setId(0, 0, 0, 0, 0, 0, 2'b00);
        applyStimulus(1, 0, 5, 5, 1, 1, 0, 0);  step("alu_fwd_stage1");
        applyStimulus(1, 0, 6, 5, 1, 2, 0, 0);  step("alu_fwd_stage2");
        applyStimulus(1, 0, 5, 6, 0, 2, 0, 0);  step("alu_fwd_drain");

        // Load-use on x7: one stall cycle, then forward from stage 2.
        setId(1, 7, 1, 1, 0, 1, 2'b01);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);  step("lw_issue");
        setId(1, 8, 1, 0, 2, 7, 2'b11);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);  step("lu_stall");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);  step("lu_release");
        setId(0, 0, 0, 0, 0, 0, 2'b00);
        applyStimulus(1, 0, 2, 7, 0, 2, 0, 1);  step("lu_fwd_stage2");
        applyStimulus(1, 0, 8, 8, 1, 1, 0, 1);  step("lu_dep_chain");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);  step("idle0");

        // Priority between two x3 writers, and x0 handling.
        setId(1, 3, 1, 0, 0, 0, 2'b00);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);  step("x3_first");
        applyStimulus(1, 0, 3, 3, 0, 0, 0, 1);  step("x3_second");
        setId(1, 0, 1, 0, 0, 0, 2'b00);
        applyStimulus(1, 0, 3, 3, 1, 1, 0, 1);  step("x3_stage1");
        setId(0, 0, 0, 0, 0, 0, 2'b00);
        applyStimulus(1, 0, 3, 3, 1, 1, 0, 1);  step("x3_priority");
        setId(1, 0, 1, 1, 0, 0, 2'b00);
        applyStimulus(1, 0, 0, 3, 0, 2, 0, 1);  step("x0_no_fwd");
        setId(1, 4, 1, 0, 0, 0, 2'b11);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);  step("x0_no_stall");
        setId(0, 0, 0, 0, 0, 0, 2'b00);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);  step("drain1");
        applyStimulus(1, 0, 4, 0, 1, 0, 0, 1);  step("drain2");
        applyStimulus(1, 0, 0, 4, 0, 2, 0, 1);  step("drain3");

        // Flush masks a load-use, then a held pipeline (flush included).
        setId(1, 10, 1, 1, 0, 0, 2'b00);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);   step("lw10_issue");
        setId(1, 11, 1, 0, 0, 10, 2'b01);
        applyStimulus(1, 1, 10, 10, 0, 0, 0, 1); step("flush_masks_stall");
        setId(1, 12, 1, 1, 0, 0, 2'b00);
        applyStimulus(1, 0, 10, 10, 1, 1, 0, 1); step("flush_bubble");
        setId(1, 13, 1, 0, 12, 5, 2'b11);
        applyStimulus(0, 0, 11, 10, 0, 2, 1, 1); step("hold_1");
        applyStimulus(0, 1, 11, 10, 0, 2, 0, 1); step("hold_2_flush");
        applyStimulus(0, 0, 11, 10, 0, 2, 1, 1); step("hold_3");
        applyStimulus(1, 0, 11, 10, 0, 2, 1, 1); step("hold_release_stall");
        applyStimulus(1, 0, 10, 12, 0, 1, 0, 2); step("post_stall_fwd");

        // Unused source never stalls, but selects are still computed.
        setId(1, 9, 1, 1, 0, 0, 2'b00);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2);   step("lw9_issue");
        setId(1, 14, 1, 0, 9, 1, 2'b01);
        applyStimulus(1, 0, 9, 13, 0, 1, 0, 2);  step("unused_src_no_stall");
        setId(0, 0, 0, 0, 0, 0, 2'b00);
        applyStimulus(1, 0, 9, 13, 1, 2, 0, 2);  step("unused_src_fwd");

        // Five load-use stalls drive the 2-bit counter into saturation.
        for (int i = 0; i < 5; i++) begin
            setId(1, 20, 1, 1, 0, 0, 2'b00);
            applyStimulus(1, 0, 0, 0, 0, 0, 0, (i == 0) ? 2'd2 : 2'd3);
            step("sat_lw");
            setId(1, 21, 1, 0, 0, 20, 2'b01);
            applyStimulus(1, 0, 0, 0, 0, 0, 1, (i == 0) ? 2'd2 : 2'd3);
            step("sat_stall");
        end
        setId(1, 22, 1, 1, 0, 0, 2'b00);
        applyStimulus(1, 0, 20, 20, 1, 1, 0, 3); step("sat_hold");

        // Asynchronous reset in the middle of a cycle with live hazards.
        setId(1, 23, 1, 0, 0, 22, 2'b01);
        applyStimulus(1, 0, 20, 20, 2, 2, 1, 3);
        checkOutput("pre_reset");
        reset = 1'b1;
        pushExpect('0, 1'b0, '0);
        checkOutput("async_reset");
        tick();
        reset = 1'b0;
        applyStimulus(1, 0, 20, 20, 0, 0, 0, 0); step("post_reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
